wb_split_tmo: RTL

WB_SPLIT_TMO -- requirements
Module: wb_split_tmo

---
 rtl/wb_split_pkg.sv | 18 +
 rtl/wb_tmo_counter.sv | 30 +++
 rtl/wb_split_tmo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_split_pkg.sv
// Shared types and constant helpers for the Wishbone split/timeout block.
package wb_split_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } state_t;

  // Ceiling log2, never less than 1 so derived vectors keep a legal width.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/wb_tmo_counter.sv
// Slave-response watchdog: counts enabled cycles, flags the last allowed one.
module wb_tmo_counter
  import wb_split_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count while enabled; hold at the final value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/wb_split_tmo.sv
// Wishbone 1-to-N address-decoded splitter with slave-response timeout.
module wb_split_tmo
  import wb_split_pkg::*;
#(
  parameter int unsigned NUM_PERIPHERALS  = 27,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned SEL_WIDTH        = 4,
  parameter int unsigned ADDR_SEL_LOW_BIT = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_i,
  input  logic                                   m_wb_cyc_i,
  input  logic                                   m_wb_stb_i,
  input  logic                                   m_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]                  m_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                  m_wb_dat_i,
  input  logic [SEL_WIDTH-1:0]                   m_wb_sel_i,
  output logic [DATA_WIDTH-1:0]                  m_wb_dat_o,
  output logic                                   m_wb_ack_o,
  output logic                                   m_wb_err_o,
  output logic [NUM_PERIPHERALS-1:0]             s_wb_cyc_o,
  output logic [NUM_PERIPHERALS-1:0]             s_wb_stb_o,
  output logic [NUM_PERIPHERALS-1:0]             s_wb_we_o,
  output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0]  s_wb_adr_o,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0]  s_wb_dat_o,
  output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]   s_wb_sel_o,
  input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0]  s_wb_dat_i,
  input  logic [NUM_PERIPHERALS-1:0]             s_wb_ack_i,
  input  logic [NUM_PERIPHERALS-1:0]             s_wb_err_i,
  output logic                                   tmo_flag_o,
  input  logic                                   tmo_clr_i,
  output logic [ADDR_WIDTH-1:0]                  err_adr_o
);

  localparam int unsigned IDXW = clog2_min1(NUM_PERIPHERALS);
  localparam logic [IDXW:0] NP_LIMIT = (IDXW + 1)'(NUM_PERIPHERALS);

  state_t state_q, state_d;

  logic [IDXW-1:0]       idx_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  we_q;

  logic [IDXW-1:0]       idx_in;
  logic                  in_range;
  logic [NUM_PERIPHERALS-1:0] sel_vec;
  logic                  sel_ack, sel_err;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  accept, decode_err, fin_ack, fin_err, tmo_hit;
  logic                  expire;

  assign idx_in   = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDXW];
  assign in_range = ({1'b0, idx_in} < NP_LIMIT);

  wb_tmo_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (state_q != ACTIVE),
    .enable(state_q == ACTIVE),
    .expire(expire)
  );

  // One-hot slave select and response mux for the latched slave only.
  always_comb begin
    sel_vec = '0;
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_PERIPHERALS; i++) begin
      if (idx_q == i[IDXW-1:0]) begin
        sel_vec[i] = (state_q == ACTIVE);
        sel_ack    = s_wb_ack_i[i];
        sel_err    = s_wb_err_i[i];
        sel_dat    = s_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign s_wb_cyc_o = sel_vec;
  assign s_wb_stb_o = sel_vec;
  assign s_wb_we_o  = {NUM_PERIPHERALS{we_q}};
  assign s_wb_adr_o = {NUM_PERIPHERALS{adr_q}};
  assign s_wb_dat_o = {NUM_PERIPHERALS{dat_q}};
  assign s_wb_sel_o = {NUM_PERIPHERALS{sel_q}};

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state; master abort beats any response, slave err beats ack, ack beats timeout.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    decode_err = 1'b0;
    fin_ack    = 1'b0;
    fin_err    = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_wb_cyc_i && m_wb_stb_i) begin
          if (in_range) begin
            state_d = ACTIVE;
            accept  = 1'b1;
          end else begin
            state_d    = RESP;
            decode_err = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!m_wb_cyc_i) begin
          state_d = IDLE;
        end else if (sel_err) begin
          state_d = RESP;
          fin_err = 1'b1;
        end else if (sel_ack) begin
          state_d = RESP;
          fin_ack = 1'b1;
        end else if (expire) begin
          state_d = RESP;
          tmo_hit = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches, registered master response, sticky error flag and address.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      m_wb_dat_o <= '0;
      tmo_flag_o <= 1'b0;
      err_adr_o  <= '0;
    end else begin
      m_wb_ack_o <= fin_ack;
      m_wb_err_o <= fin_err || tmo_hit || decode_err;
      if (accept) begin
        idx_q <= idx_in;
        adr_q <= m_wb_adr_i;
        dat_q <= m_wb_dat_i;
        sel_q <= m_wb_sel_i;
        we_q  <= m_wb_we_i;
      end
      if (fin_ack) m_wb_dat_o <= sel_dat;
      else if (fin_err || tmo_hit || decode_err) m_wb_dat_o <= '0;
      if (tmo_hit || decode_err) tmo_flag_o <= 1'b1;
      else if (tmo_clr_i)        tmo_flag_o <= 1'b0;
      if (decode_err)   err_adr_o <= m_wb_adr_i;
      else if (tmo_hit) err_adr_o <= adr_q;
    end
  end

endmodule
